fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the single write port of the synchronous FIFO (`syn_fifo`) between `NUM_REQ` producers. Each grant is held for a burst of up to `MAX_BURST` beats, and the block applies backpressure from the FIFO's full/almost-full status. FIFO-side outputs are registered, so a beat accepted from a producer reaches the FIFO write port one cycle later.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 141 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write arbiter.
// Optional stats counters are enabled by FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;
  localparam int STAT_W         = 32;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// First set bit of req strictly after last, wrapping to 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [N-1:0] gt;
  logic [N-1:0] hi;
  logic [N-1:0] sel;
  logic [N-1:0] oh;
  logic [N-1:0] bmask [IW];

  for (genvar i = 0; i < N; i++) begin : g_gt
    assign gt[i] = (IW+1)'(i) > {1'b0, last};
  end

  assign hi    = req & gt;
  assign sel   = (|hi) ? hi : req;
  assign oh    = sel & (~sel + 1'b1);
  assign found = |req;

  for (genvar b = 0; b < IW; b++) begin : g_enc
    for (genvar i = 0; i < N; i++) begin : g_m
      assign bmask[b][i] = ((i >> b) & 1) == 1;
    end
    assign idx[b] = |(oh & bmask[b]);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the syn_fifo write port.
// Define FIFO_ARB_STATS_EN to add stat_beats / stat_stalls outputs.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]             stat_beats,
  output logic [STAT_W-1:0]             stat_stalls
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

  arb_state_e      state, state_d;
  logic [IW-1:0]   owner, owner_d;
  logic [IW-1:0]   last_owner, last_d;
  logic [CW-1:0]   beat_cnt, cnt_d;
  logic            wr_q, wr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [DATA_WIDTH-1:0] dat [NUM_REQ];
  logic            own_valid;
  logic [DATA_WIDTH-1:0] own_data;
  logic            space_ok;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dat
    assign dat[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign own_valid = req_valid[owner];
  assign own_data  = dat[owner];

  // the in-flight write may take the last free slot
  assign space_ok = !fifo_full && !(wr_q && fifo_almost_full);

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .last  (last_owner),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // next-state, accept and write-pipe decode
  always_comb begin
    state_d   = state;
    owner_d   = owner;
    last_d    = last_owner;
    cnt_d     = beat_cnt;
    wr_d      = 1'b0;
    data_d    = data_q;
    req_ready = '0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_found && space_ok) begin
          state_d = ARB_GRANT;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (!own_valid) begin
          state_d = ARB_IDLE;
          last_d  = owner;
        end else if (space_ok) begin
          req_ready = NUM_REQ'(1) << owner;
          wr_d      = 1'b1;
          data_d    = own_data;
          cnt_d     = beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            state_d = ARB_IDLE;
            last_d  = owner;
          end
        end
      end
    endcase
  end

  // state and registered FIFO-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      last_owner <= LAST_REQ;
      beat_cnt   <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_d;
      beat_cnt   <= cnt_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
    end
  end

  assign fifo_wr_cs = wr_q;
  assign fifo_wr_en = wr_q;
  assign fifo_data  = data_q;
  assign busy       = (state == ARB_GRANT);

`ifdef FIFO_ARB_STATS_EN
  logic stall;
  assign stall = busy && own_valid && !space_ok;

  // saturating write and stall counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (wr_q) stat_beats <= sat_inc(stat_beats);
      if (stall) stat_stalls <= sat_inc(stat_stalls);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter.
// Producers are modelled as counters; FIFO writes go to a queue.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          fifo_wr_cs;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data;
  logic          busy;
`ifdef FIFO_ARB_STATS_EN
  logic [31:0]   stat_beats;
  logic [31:0]   stat_stalls;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .MAX_BURST(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wr_cs       (fifo_wr_cs),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_data        (fifo_data),
    .busy             (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_beats       (stat_beats),
    .stat_stalls      (stat_stalls)
`endif
  );

  int n_chk;
  int n_fail;
  int cyc;
  int n_cs;
  logic [7:0] cnt [NR];
  logic [7:0] lim [NR];
  logic [7:0] base [NR];
  logic [NR-1:0] en;
  logic [7:0] wq [$];
  int wcyc [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++)
      req_valid[i] = en[i] && (cnt[i] < lim[i]);
    req_data = {8'(base[3] + cnt[3]), 8'(base[2] + cnt[2]),
                8'(base[1] + cnt[1]), 8'(base[0] + cnt[0])};
  endtask

  task automatic tick();
    logic [NR-1:0] x;
    x = req_valid & req_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (fifo_wr_en) begin
      wq.push_back(fifo_data);
      wcyc.push_back(cyc);
    end
    if (fifo_wr_cs) n_cs++;
    for (int i = 0; i < NR; i++)
      if (x[i]) cnt[i]++;
    drive();
    #1;
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    drive();
    #1;
    repeat (n) tick();
  endtask

  task automatic release_reset();
    for (int i = 0; i < NR; i++) cnt[i] = 8'd0;
    rst_n = 1'b1;
    drive();
    cyc = 0;
    n_cs = 0;
    wq.delete();
    wcyc.delete();
    #1;
  endtask

  task automatic set_prod(input int i, input logic [7:0] l,
                          input logic [7:0] b);
    lim[i] = l;
    base[i] = b;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    n_cs = 0;
    rst_n = 1'b0;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      lim[i] = 0;
      base[i] = 0;
    end
    en = '0;
    drive();

    // reset with all requesters valid
    for (int i = 0; i < NR; i++) set_prod(i, 8'd100, 8'(i * 16));
    en = 4'b1111;
    hold_reset(3);
    check("rst_busy", busy, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_cs", fifo_wr_cs, 0);
    check("rst_data", fifo_data, 0);
    check("rst_ready", req_ready, 0);
    release_reset();
    tick();
    check("first_grant", req_ready, 4'b0001);
    check("first_busy", busy, 1);

    // two full-length bursts
    en = 4'b0101;
    set_prod(0, 8'd4, 8'h10);
    set_prod(2, 8'd4, 8'h20);
    hold_reset(1);
    release_reset();
    repeat (14) begin
      tick();
      if (cyc == 5) check("gap_idle", busy, 0);
    end
    check("burst_cnt", wq.size(), 8);
    check("burst_cs", n_cs, 8);
    for (int k = 0; k < 8; k++)
      check("burst_data", wq[k],
            (k < 4) ? 32'h10 + k : 32'h20 + k - 4);
    check("latency", wcyc[0], 2);
    check("gap_len", wcyc[4] - wcyc[3], 2);
    check("data_hold", fifo_data, 8'h23);

    // early release by requester 1
    en = 4'b0010;
    set_prod(0, 8'd1, 8'h50);
    set_prod(1, 8'd2, 8'h40);
    set_prod(3, 8'd1, 8'h30);
    hold_reset(1);
    release_reset();
    tick();
    en = 4'b1011;
    drive();
    #1;
    check("er_owner1", req_ready, 4'b0010);
    repeat (3) tick();
    check("er_release", busy, 0);
    tick();
    check("er_grant3", req_ready, 4'b1000);
    repeat (3) tick();
    check("er_grant0", req_ready, 4'b0001);
    repeat (3) tick();
    check("er_cnt", wq.size(), 4);
    check("er_d0", wq[0], 8'h40);
    check("er_d1", wq[1], 8'h41);
    check("er_d2", wq[2], 8'h30);
    check("er_d3", wq[3], 8'h50);

    // backpressure: almost_full, then full
    en = 4'b0001;
    set_prod(0, 8'd4, 8'h60);
    hold_reset(1);
    release_reset();
    repeat (2) tick();
    fifo_almost_full = 1'b1;
    #1;
    check("af_inflight", fifo_wr_en, 1);
    check("af_ready", req_ready, 0);
    tick();
    check("af_nowrite", fifo_wr_en, 0);
    check("af_oneslot", req_ready, 4'b0001);
    fifo_almost_full = 1'b0;
    #1;
    tick();
    fifo_full = 1'b1;
    #1;
    check("full_ready", req_ready, 0);
    repeat (5) tick();
    check("full_nowr", wq.size(), 2);
    check("full_hold", busy, 1);
    fifo_full = 1'b0;
    #1;
    repeat (6) tick();
    check("bp_cnt", wq.size(), 4);
    for (int k = 0; k < 4; k++)
      check("bp_data", wq[k], 32'h60 + k);
    check("bp_done", busy, 0);

    // reset in the middle of a burst
    en = 4'b0100;
    set_prod(0, 8'd100, 8'h00);
    set_prod(2, 8'd100, 8'h70);
    hold_reset(1);
    release_reset();
    repeat (3) tick();
    check("mid_beats", wq.size(), 2);
    rst_n = 1'b0;
    en = 4'b0101;
    drive();
    #1;
    tick();
    check("mid_busy", busy, 0);
    check("mid_wr_en", fifo_wr_en, 0);
    check("mid_data", fifo_data, 0);
    check("mid_ready", req_ready, 0);
    release_reset();
    tick();
    check("mid_regrant", req_ready, 4'b0001);

    // bursts with three stall cycles
    en = 4'b0101;
    set_prod(0, 8'd4, 8'h10);
    set_prod(2, 8'd4, 8'h20);
    hold_reset(1);
`ifdef FIFO_ARB_STATS_EN
    check("st_rst_b", stat_beats, 0);
    check("st_rst_s", stat_stalls, 0);
`endif
    release_reset();
    tick();
    fifo_full = 1'b1;
    #1;
    repeat (3) tick();
    fifo_full = 1'b0;
    #1;
    repeat (16) tick();
    check("st_writes", wq.size(), 8);
`ifdef FIFO_ARB_STATS_EN
    check("st_beats", stat_beats, 8);
    check("st_stalls", stat_stalls, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
